rf_write_arbiter: RTL and testbench

Write-side front end of the integer register file. Merges the in-order pipeline writeback stream with results from long-latency units (divider, multi-cycle load path) into the register file's single write port (`we3`/`a3`/`wd3`). Tracks which registers still await a long-latency result and raises a decode-stage stall on read-after-write, write-after-write and issue conflicts. Sits between the WB stage, the long-latency units and the register file.

---
 rtl/rf_pkg.sv | 13 +
 rtl/rf_write_arbiter_if.sv | 40 ++++
 rtl/wb_result_fifo.sv | 45 ++++
 rtl/rf_write_arbiter.sv | 103 ++++++++++
 tb/tb_rf_write_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rf_pkg.sv
// Shared types for the register-file write side.
// Holds the address width, the data width and the queued long-latency result entry.
package rf_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned XLEN       = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Signal bundle between decode/WB/long-latency units (master) and the write arbiter (slave).
interface rf_write_arbiter_if #(
    parameter int unsigned XLEN = 32
) ();
    import rf_pkg::*;

    logic                  pipe_we;
    logic [REG_ADDR_W-1:0] pipe_rd;
    logic [XLEN-1:0]       pipe_data;
    logic                  pipe_stall;

    logic                  mc_valid;
    logic                  mc_ready;
    logic [REG_ADDR_W-1:0] mc_rd;
    logic [XLEN-1:0]       mc_data;

    logic                  iss_valid;
    logic [REG_ADDR_W-1:0] iss_rd;
    logic [REG_ADDR_W-1:0] q_a1;
    logic [REG_ADDR_W-1:0] q_a2;
    logic [REG_ADDR_W-1:0] q_rd;
    logic                  id_stall;

    logic                  we3;
    logic [REG_ADDR_W-1:0] a3;
    logic [XLEN-1:0]       wd3;

    modport master (
        output pipe_we, pipe_rd, pipe_data, mc_valid, mc_rd, mc_data,
               iss_valid, iss_rd, q_a1, q_a2, q_rd,
        input  pipe_stall, mc_ready, id_stall, we3, a3, wd3
    );

    modport slave (
        input  pipe_we, pipe_rd, pipe_data, mc_valid, mc_rd, mc_data,
               iss_valid, iss_rd, q_a1, q_a2, q_rd,
        output pipe_stall, mc_ready, id_stall, we3, a3, wd3
    );

endinterface

// File: rtl/wb_result_fifo.sv
// Small synchronous FIFO holding long-latency results until the write port is free.
module wb_result_fifo #(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned CntW = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  rf_pkg::wb_entry_t wdata,
    input  logic              pop,
    output rf_pkg::wb_entry_t head,
    output logic [CntW-1:0]   count,
    output logic              empty
);
    import rf_pkg::*;

    localparam int unsigned AW = $clog2(DEPTH);

    wb_entry_t       mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [CntW-1:0] count_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CntW'(push) - CntW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wdata;
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign empty = (count_q == '0);

endmodule

// File: rtl/rf_write_arbiter.sv
// Merges WB writes and queued long-latency results onto the single register-file write port,
// tracks registers awaiting long-latency results and raises the decode hazard stall.
module rf_write_arbiter #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned DEPTH        = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input logic               clk,
    input logic               rst_n,
    rf_write_arbiter_if.slave bus
);
    import rf_pkg::*;

    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    wb_entry_t             push_entry;
    wb_entry_t             head;
    logic                  push;
    logic                  pop;
    logic                  fifo_empty;
    logic [CntW-1:0]       fifo_count;
    logic                  force_head;

    logic                  we_sel;
    logic [REG_ADDR_W-1:0] a_sel;
    logic [XLEN-1:0]       wd_sel;
    logic                  pipe_stall;

    logic [31:0]           busy_q, busy_d;
    logic [3:0]            starve_q, starve_d;

    // Ready depends on registered occupancy only, so a pop never makes room in the same cycle.
    assign bus.mc_ready = (fifo_count < CntW'(DEPTH));
    assign push         = bus.mc_valid && bus.mc_ready && (bus.mc_rd != '0);
    assign push_entry   = '{rd: bus.mc_rd, data: bus.mc_data};

    wb_result_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (push_entry),
        .pop   (pop),
        .head  (head),
        .count (fifo_count),
        .empty (fifo_empty)
    );

    assign force_head = !fifo_empty && (starve_q == 4'(STARVE_LIMIT));

    always_comb begin
        we_sel     = 1'b0;
        a_sel      = '0;
        wd_sel     = '0;
        pop        = 1'b0;
        pipe_stall = 1'b0;
        if (force_head) begin
            we_sel     = 1'b1;
            a_sel      = head.rd;
            wd_sel     = head.data;
            pop        = 1'b1;
            pipe_stall = bus.pipe_we;
        end else if (bus.pipe_we) begin
            we_sel = 1'b1;
            a_sel  = bus.pipe_rd;
            wd_sel = bus.pipe_data;
        end else if (!fifo_empty) begin
            we_sel = 1'b1;
            a_sel  = head.rd;
            wd_sel = head.data;
            pop    = 1'b1;
        end
    end

    assign bus.we3        = we_sel;
    assign bus.a3         = a_sel;
    assign bus.wd3        = wd_sel;
    assign bus.pipe_stall = pipe_stall;

    // Issue after pop so a same-cycle set of the same register wins.
    always_comb begin
        busy_d = busy_q;
        if (pop) busy_d[head.rd] = 1'b0;
        if (bus.iss_valid && (bus.iss_rd != '0)) busy_d[bus.iss_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    assign starve_d = (!fifo_empty && bus.pipe_we && !pop) ? starve_q + 4'd1 : 4'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q   <= '0;
            starve_q <= '0;
        end else begin
            busy_q   <= busy_d;
            starve_q <= starve_d;
        end
    end

    assign bus.id_stall = busy_q[bus.q_a1] | busy_q[bus.q_a2] | busy_q[bus.q_rd];

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: directed scenarios with literal expectations plus randomized
// traffic, all outputs compared every cycle against a queue-based reference model.
module tb_rf_write_arbiter;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned LIMIT = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    rf_write_arbiter_if #(.XLEN(32)) bus ();

    rf_write_arbiter #(
        .XLEN         (32),
        .DEPTH        (DEPTH),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t m_q[$];
    bit   m_busy[32];
    int   m_starve;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // What the write port, stalls and ready must be given the model state and current inputs.
    task automatic model_outputs(output logic we, output logic [4:0] a, output logic [31:0] d,
                                 output logic ps, output logic rdy, output logic ids,
                                 output logic pop);
        bit nonempty;
        nonempty = (m_q.size() > 0);
        we = 0; a = 0; d = 0; ps = 0; pop = 0;
        if (nonempty && m_starve == LIMIT) begin
            we = 1; a = m_q[0].rd; d = m_q[0].data; ps = bus.pipe_we; pop = 1;
        end else if (bus.pipe_we) begin
            we = 1; a = bus.pipe_rd; d = bus.pipe_data;
        end else if (nonempty) begin
            we = 1; a = m_q[0].rd; d = m_q[0].data; pop = 1;
        end
        rdy = (m_q.size() < DEPTH);
        ids = m_busy[bus.q_a1] | m_busy[bus.q_a2] | m_busy[bus.q_rd];
    endtask

    task automatic model_step();
        logic we, ps, rdy, ids, pop;
        logic [4:0] a;
        logic [31:0] d;
        bit nonempty;
        ent_t h;
        ent_t e;
        model_outputs(we, a, d, ps, rdy, ids, pop);
        nonempty = (m_q.size() > 0);
        if (pop) begin
            h = m_q.pop_front();
            m_busy[h.rd] = 0;
        end
        if (bus.mc_valid && rdy && bus.mc_rd != 0) begin
            e.rd = bus.mc_rd;
            e.data = bus.mc_data;
            m_q.push_back(e);
        end
        if (bus.iss_valid && bus.iss_rd != 0) m_busy[bus.iss_rd] = 1;
        m_starve = (nonempty && bus.pipe_we && !pop) ? m_starve + 1 : 0;
    endtask

    initial begin
        forever begin
            @(negedge rst_n);
            m_q.delete();
            foreach (m_busy[i]) m_busy[i] = 0;
            m_starve = 0;
        end
    end

    // Compare process: every cycle against the model, then advance the model on the edge.
    initial begin
        logic we, ps, rdy, ids, pop;
        logic [4:0] a;
        logic [31:0] d;
        forever begin
            @(negedge clk);
            model_outputs(we, a, d, ps, rdy, ids, pop);
            chk("m_we3", 32'(bus.we3), 32'(we));
            chk("m_a3", 32'(bus.a3), 32'(a));
            chk("m_wd3", bus.wd3, d);
            chk("m_pipe_stall", 32'(bus.pipe_stall), 32'(ps));
            chk("m_mc_ready", 32'(bus.mc_ready), 32'(rdy));
            chk("m_id_stall", 32'(bus.id_stall), 32'(ids));
            @(posedge clk);
            if (rst_n) model_step();
        end
    end

    task automatic idle();
        bus.pipe_we = 0; bus.pipe_rd = 0; bus.pipe_data = 0;
        bus.mc_valid = 0; bus.mc_rd = 0; bus.mc_data = 0;
        bus.iss_valid = 0; bus.iss_rd = 0;
        bus.q_a1 = 0; bus.q_a2 = 0; bus.q_rd = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic hold_pipe, hold_mc;

    initial begin
        idle();
        #1 rst_n = 0;
        repeat (2) tick();
        @(negedge clk);
        chk("reset_we3", 32'(bus.we3), 0);
        chk("reset_mc_ready", 32'(bus.mc_ready), 1);
        chk("reset_id_stall", 32'(bus.id_stall), 0);
        chk("reset_pipe_stall", 32'(bus.pipe_stall), 0);
        tick();
        rst_n = 1;
        tick();

        // Scoreboard round trip on x5.
        bus.iss_valid = 1; bus.iss_rd = 5; bus.q_rd = 5;
        tick();
        bus.iss_valid = 0; bus.q_rd = 0; bus.q_a1 = 5;
        bus.mc_valid = 1; bus.mc_rd = 5; bus.mc_data = 32'hDEADBEEF;
        @(negedge clk);
        chk("sb_stall_set", 32'(bus.id_stall), 1);
        chk("sb_model_busy", 32'(m_busy[5]), 1);
        chk("sb_no_write_yet", 32'(bus.we3), 0);
        tick();
        bus.mc_valid = 0;
        @(negedge clk);
        chk("sb_we3", 32'(bus.we3), 1);
        chk("sb_a3", 32'(bus.a3), 5);
        chk("sb_wd3", bus.wd3, 32'hDEADBEEF);
        chk("sb_stall_during_pop", 32'(bus.id_stall), 1);
        tick();
        @(negedge clk);
        chk("sb_stall_clear", 32'(bus.id_stall), 0);
        chk("sb_port_idle", 32'(bus.we3), 0);
        tick();
        idle();

        // Pipe beats FIFO when not forced.
        bus.pipe_we = 1; bus.pipe_rd = 3; bus.pipe_data = 32'h1111_0003;
        bus.mc_valid = 1; bus.mc_rd = 7; bus.mc_data = 32'h7777_0007;
        @(negedge clk);
        chk("prio_a3", 32'(bus.a3), 3);
        chk("prio_wd3", bus.wd3, 32'h1111_0003);
        chk("prio_pipe_stall", 32'(bus.pipe_stall), 0);
        tick();
        idle();
        @(negedge clk);
        chk("prio_fifo_we3", 32'(bus.we3), 1);
        chk("prio_fifo_a3", 32'(bus.a3), 7);
        chk("prio_fifo_wd3", bus.wd3, 32'h7777_0007);
        tick();
        @(negedge clk);
        chk("prio_drained", 32'(bus.we3), 0);
        tick();

        // Full FIFO with the pipe busy; third offer must be held and later accepted.
        bus.pipe_we = 1; bus.pipe_rd = 1; bus.pipe_data = 32'hA1;
        bus.mc_valid = 1; bus.mc_rd = 10; bus.mc_data = 32'h10;
        @(negedge clk); chk("full_rdy_c1", 32'(bus.mc_ready), 1);
        tick();
        bus.pipe_rd = 2; bus.pipe_data = 32'hA2; bus.mc_rd = 11; bus.mc_data = 32'h11;
        @(negedge clk); chk("full_rdy_c2", 32'(bus.mc_ready), 1);
        tick();
        bus.pipe_rd = 3; bus.pipe_data = 32'hA3; bus.mc_rd = 12; bus.mc_data = 32'h12;
        @(negedge clk); chk("full_rdy_c3", 32'(bus.mc_ready), 0);
        tick();
        bus.pipe_we = 0;
        @(negedge clk);
        chk("full_rdy_c4", 32'(bus.mc_ready), 0);
        chk("full_pop10", 32'(bus.a3), 10);
        tick();
        @(negedge clk);
        chk("full_rdy_rise", 32'(bus.mc_ready), 1);
        chk("full_pop11", 32'(bus.a3), 11);
        tick();
        bus.mc_valid = 0;
        @(negedge clk);
        chk("full_held_a3", 32'(bus.a3), 12);
        chk("full_held_wd3", bus.wd3, 32'h12);
        tick();
        idle();
        @(negedge clk); chk("full_drained", 32'(bus.we3), 0);
        tick();

        // Starvation: entry x9 with the pipe writing every cycle.
        bus.pipe_we = 1; bus.pipe_rd = 20; bus.pipe_data = 32'hB020;
        bus.mc_valid = 1; bus.mc_rd = 9; bus.mc_data = 32'h9999;
        tick();
        bus.mc_valid = 0;
        for (int i = 1; i <= 4; i++) begin
            bus.pipe_rd = 5'(20 + i); bus.pipe_data = 32'hB020 + 32'(i);
            @(negedge clk);
            chk("starve_pipe_a3", 32'(bus.a3), 32'(20 + i));
            chk("starve_no_stall", 32'(bus.pipe_stall), 0);
            tick();
        end
        bus.pipe_rd = 25; bus.pipe_data = 32'hB025;
        @(negedge clk);
        chk("starve_force_a3", 32'(bus.a3), 9);
        chk("starve_force_wd3", bus.wd3, 32'h9999);
        chk("starve_force_stall", 32'(bus.pipe_stall), 1);
        tick();
        @(negedge clk);
        chk("starve_retry_a3", 32'(bus.a3), 25);
        chk("starve_retry_wd3", bus.wd3, 32'hB025);
        chk("starve_retry_stall", 32'(bus.pipe_stall), 0);
        tick();
        idle();

        // x0: no enqueue, no busy bit.
        bus.mc_valid = 1; bus.mc_rd = 0; bus.mc_data = 32'h5555;
        bus.iss_valid = 1; bus.iss_rd = 0;
        @(negedge clk); chk("x0_ready", 32'(bus.mc_ready), 1);
        tick();
        idle();
        @(negedge clk);
        chk("x0_no_we3", 32'(bus.we3), 0);
        chk("x0_no_stall", 32'(bus.id_stall), 0);
        chk("x0_model_empty", 32'(m_q.size()), 0);
        tick();

        // Reset mid-traffic with two pending entries.
        bus.iss_valid = 1; bus.iss_rd = 13; bus.q_rd = 13;
        tick();
        bus.iss_rd = 14; bus.q_rd = 14;
        tick();
        bus.iss_valid = 0; bus.q_rd = 0;
        bus.pipe_we = 1; bus.pipe_rd = 1; bus.pipe_data = 32'hC1;
        bus.mc_valid = 1; bus.mc_rd = 13; bus.mc_data = 32'h13;
        tick();
        bus.mc_rd = 14; bus.mc_data = 32'h14;
        tick();
        bus.mc_valid = 0; bus.q_a1 = 13;
        @(negedge clk);
        chk("rst_pre_full", 32'(bus.mc_ready), 0);
        chk("rst_pre_stall", 32'(bus.id_stall), 1);
        tick();
        idle();
        bus.q_a1 = 13; bus.q_a2 = 14;
        rst_n = 0;
        #1;
        chk("rst_mid_we3", 32'(bus.we3), 0);
        chk("rst_mid_ready", 32'(bus.mc_ready), 1);
        chk("rst_mid_stall", 32'(bus.id_stall), 0);
        tick();
        rst_n = 1;
        @(negedge clk);
        chk("rst_after_we3", 32'(bus.we3), 0);
        chk("rst_after_stall", 32'(bus.id_stall), 0);
        tick();
        idle();

        // Randomized traffic; pipe and long-latency sources hold while stalled.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            hold_pipe = bus.pipe_stall;
            hold_mc   = bus.mc_valid && !bus.mc_ready;
            @(posedge clk);
            #1;
            if (!hold_pipe) begin
                bus.pipe_we   = ($urandom_range(0, 99) < ((c < 1500) ? 90 : 50));
                bus.pipe_rd   = 5'($urandom_range(0, 7));
                bus.pipe_data = $urandom;
            end
            if (!hold_mc) begin
                bus.mc_valid = ($urandom_range(0, 99) < 35);
                bus.mc_rd    = 5'($urandom_range(0, 7));
                bus.mc_data  = $urandom;
            end
            bus.q_a1 = 5'($urandom_range(0, 7));
            bus.q_a2 = 5'($urandom_range(0, 7));
            bus.q_rd = 5'($urandom_range(0, 7));
            bus.iss_rd = bus.q_rd;
            bus.iss_valid = !(m_busy[bus.q_a1] | m_busy[bus.q_a2] | m_busy[bus.q_rd])
                            && ($urandom_range(0, 99) < 25);
        end
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
